// File: rtl/conv_to_montgomery.sv
// Conventional -> Montgomery domain conversion: y = a * 2^m_size mod m,
// by one reducing subtract on load followed by m_size modular doublings.
module conv_to_montgomery #(
  parameter  int NBITS = 2048,
  localparam int KW    = $clog2(NBITS) + 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_p,
  input  logic [NBITS-1:0] a,
  input  logic [NBITS-1:0] m,
  input  logic [KW-1:0]    m_size,
  output logic [NBITS-1:0] y,
  output logic             done_irq_p
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [NBITS:0]   x_q, x_d;
  logic [KW-1:0]    cnt_q, cnt_d;
  logic [NBITS-1:0] m_q, m_d;
  logic [KW-1:0]    k_q, k_d;
  logic [NBITS-1:0] y_q, y_d;
  logic             done_q, done_d;

  logic [NBITS:0]   t;
  logic [NBITS:0]   mx;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    cnt_d   = cnt_q;
    m_d     = m_q;
    k_d     = k_q;
    y_d     = y_q;
    done_d  = 1'b0;
    // x < m keeps the top bit clear, so doubling fits in NBITS+1 bits
    t       = {x_q[NBITS-1:0], 1'b0};
    mx      = {1'b0, m_q};
    case (state_q)
      IDLE: begin
        if (enable_p) begin
          x_d     = {1'b0, a};
          m_d     = m;
          k_d     = m_size;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (x_q >= mx) x_d = x_q - mx;
        cnt_d   = k_q;
        state_d = (k_q != '0) ? SHIFT : DONE;
      end
      SHIFT: begin
        x_d   = (t >= mx) ? t - mx : t;
        cnt_d = cnt_q - KW'(1);
        if (cnt_q == KW'(1)) state_d = DONE;
      end
      DONE: begin
        y_d     = x_q[NBITS-1:0];
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      cnt_q   <= '0;
      m_q     <= '0;
      k_q     <= '0;
      y_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      k_q     <= k_d;
      y_q     <= y_d;
      done_q  <= done_d;
    end
  end

  assign y          = y_q;
  assign done_irq_p = done_q;

endmodule
